debug_page_sched: RTL

Debug display scheduler for the LED debug mux. It debounces the raw board switches and the step pushbutton, then chooses which debug page the mux shows: manual select, timed auto-scan, single-step, or freeze. It drives the page select into the LED mux, registers the mux output onto the LEDs, and can hold a snapshot while the CPU keeps running. It sits between the board I/O pins and the combinational LED page mux.

---
 rtl/debug_page_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/debug_page_sched.sv
// debug_page_sched: debounces the board switches and step button, then picks the LED debug
// page (manual, auto-scan, single-step, freeze) and registers the mux output onto the LEDs.
module debug_page_sched #(
    parameter int PAGE_COUNT      = 41,
    parameter int DWELL_CYCLES    = 25000000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn_step,
    input  logic [15:0] page_data,
    output logic [15:0] page_sel,
    output logic [15:0] led_data,
    output logic        page_changed,
    output logic [1:0]  mode
);

    localparam int PW  = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int DWW = $clog2(DWELL_CYCLES);

    localparam logic [PW-1:0]  PAGE_LAST = PW'(PAGE_COUNT - 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DWW-1:0] DW_LAST   = DWW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    logic [15:0]    sw_s1_q, sw_s2_q, sw_prev_q;
    logic [15:0]    sw_db_q, sw_db_d;
    logic [DBW-1:0] sw_cnt_q, sw_cnt_d;

    logic           btn_s1_q, btn_s2_q, btn_prev_q;
    logic           btn_db_q, btn_db_d, btn_db_dly_q;
    logic [DBW-1:0] btn_cnt_q, btn_cnt_d;

    mode_t          mode_q, mode_d, sw_mode;
    logic [PW-1:0]  page_q, page_d, page_inc;
    logic [DWW-1:0] dwell_q, dwell_d;
    logic [15:0]    led_q, led_d;
    logic           changed_q;
    logic           step_evt;
    logic           unused_sw_mid;

    // cnt counts consecutive sightings of the same synchronised value that differs from the
    // debounced copy; a new value (vs. the previous sighting) restarts the count at one.
    always_comb begin
        sw_db_d  = sw_db_q;
        sw_cnt_d = sw_cnt_q;
        if (sw_s2_q == sw_db_q) begin
            sw_cnt_d = '0;
        end else if (sw_s2_q != sw_prev_q) begin
            sw_cnt_d = DBW'(1);
        end else if (sw_cnt_q == DB_LAST) begin
            sw_db_d  = sw_s2_q;
            sw_cnt_d = '0;
        end else begin
            sw_cnt_d = sw_cnt_q + DBW'(1);
        end
    end

    always_comb begin
        btn_db_d  = btn_db_q;
        btn_cnt_d = btn_cnt_q;
        if (btn_s2_q == btn_db_q) begin
            btn_cnt_d = '0;
        end else if (btn_s2_q != btn_prev_q) begin
            btn_cnt_d = DBW'(1);
        end else if (btn_cnt_q == DB_LAST) begin
            btn_db_d  = btn_s2_q;
            btn_cnt_d = '0;
        end else begin
            btn_cnt_d = btn_cnt_q + DBW'(1);
        end
    end

    assign step_evt      = btn_db_q & ~btn_db_dly_q;
    assign sw_mode       = mode_t'(sw_db_q[15:14]);
    assign page_inc      = (page_q == PAGE_LAST) ? '0 : page_q + PW'(1);
    assign unused_sw_mid = ^sw_db_q[13:8];

    // A mode change takes the whole cycle: no advance, dwell restarts from zero.
    always_comb begin
        mode_d  = mode_q;
        page_d  = page_q;
        dwell_d = '0;
        led_d   = led_q;
        if (sw_mode != mode_q) begin
            mode_d = sw_mode;
        end else begin
            case (mode_q)
                MODE_MANUAL: begin
                    if (int'(sw_db_q[7:0]) < PAGE_COUNT) page_d = PW'(sw_db_q[7:0]);
                end
                MODE_AUTO: begin
                    if (dwell_q == DW_LAST) page_d = page_inc;
                    else                    dwell_d = dwell_q + DWW'(1);
                end
                MODE_STEP: begin
                    if (step_evt) page_d = page_inc;
                end
                default: ;
            endcase
        end
        if (mode_q != MODE_FREEZE) led_d = page_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            sw_prev_q    <= '0;
            sw_db_q      <= '0;
            sw_cnt_q     <= '0;
            btn_s1_q     <= 1'b0;
            btn_s2_q     <= 1'b0;
            btn_prev_q   <= 1'b0;
            btn_db_q     <= 1'b0;
            btn_db_dly_q <= 1'b0;
            btn_cnt_q    <= '0;
            mode_q       <= MODE_MANUAL;
            page_q       <= '0;
            dwell_q      <= '0;
            led_q        <= '0;
            changed_q    <= 1'b0;
        end else begin
            sw_s1_q      <= sw;
            sw_s2_q      <= sw_s1_q;
            sw_prev_q    <= sw_s2_q;
            sw_db_q      <= sw_db_d;
            sw_cnt_q     <= sw_cnt_d;
            btn_s1_q     <= btn_step;
            btn_s2_q     <= btn_s1_q;
            btn_prev_q   <= btn_s2_q;
            btn_db_q     <= btn_db_d;
            btn_db_dly_q <= btn_db_q;
            btn_cnt_q    <= btn_cnt_d;
            mode_q       <= mode_d;
            page_q       <= page_d;
            dwell_q      <= dwell_d;
            led_q        <= led_d;
            changed_q    <= (page_d != page_q);
        end
    end

    assign page_sel     = 16'(page_q);
    assign led_data     = led_q;
    assign page_changed = changed_q;
    assign mode         = mode_q;

endmodule
